// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared definitions for the PWM capture path: FSM state
//               encoding, counter width and the default stuck timeout used
//               alongside the simplePWM generator.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

   localparam int PWM_CNT_W = 32;

   // One second at 50 MHz: a line without edges for this long is stuck.
   localparam logic [PWM_CNT_W-1:0] PWM_TIMEOUT_DEFAULT = 32'd50_000_000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HIGH  = 2'd1,
      ST_LOW   = 2'd2,
      ST_STUCK = 2'd3
   } pwm_state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : pwm_sync_edge
// Description : Multi-flop synchroniser for an asynchronous input line with
//               registered single-cycle rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [SYNC_STAGES:0]   r_fill;
   logic                   r_dly;
   logic                   r_rise;
   logic                   r_fall;
   logic                   w_armed;
   logic                   w_rise;
   logic                   w_fall;

   // Edges are only believed once both the synchronised level and its delayed
   // copy hold real line samples, so a line that is already high when reset
   // releases does not look like a fresh rising edge.
   assign w_armed = r_fill[SYNC_STAGES];
   assign w_rise  = w_armed &  r_sync[SYNC_STAGES-1] & ~r_dly;
   assign w_fall  = w_armed & ~r_sync[SYNC_STAGES-1] &  r_dly;

   // Synchroniser chain, fill tracker, delayed level and registered edge pulses.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sync <= '0;
         r_fill <= '0;
         r_dly  <= 1'b0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
         r_fill <= {r_fill[SYNC_STAGES-1:0], 1'b1};
         r_dly  <= r_sync[SYNC_STAGES-1];
         r_rise <= w_rise;
         r_fall <= w_fall;
      end
   end

   assign o_level = r_sync[SYNC_STAGES-1];
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture
// Description : Measures period and high time of an incoming PWM line in
//               clock cycles and flags a line that stops toggling.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int                    SYNC_STAGES    = 2,
   parameter logic [PWM_CNT_W-1:0]  TIMEOUT_CYCLES = PWM_TIMEOUT_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pwm_in,
   output logic [PWM_CNT_W-1:0] period_meas,
   output logic [PWM_CNT_W-1:0] time_work_meas,
   output logic                 meas_valid,
   output logic                 stuck,
   output logic                 stuck_level
);

   localparam logic [PWM_CNT_W-1:0] c_CNT_ONE = {{(PWM_CNT_W-1){1'b0}}, 1'b1};

   logic                 w_level;
   logic                 w_rise;
   logic                 w_fall;
   logic                 w_timeout;
   logic [PWM_CNT_W-1:0] w_cnt_inc;

   pwm_state_t           r_state,  w_state_nxt;
   logic [PWM_CNT_W-1:0] r_cnt,    w_cnt_nxt;
   logic [PWM_CNT_W-1:0] r_hi_len, w_hi_len_nxt;
   logic [PWM_CNT_W-1:0] r_period, w_period_nxt;
   logic [PWM_CNT_W-1:0] r_tw,     w_tw_nxt;
   logic                 r_valid,  w_valid_nxt;
   logic                 r_stuck,  w_stuck_nxt;
   logic                 r_level,  w_level_nxt;

   pwm_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk     (clk),
      .reset   (reset),
      .i_d     (pwm_in),
      .o_level (w_level),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   // Counter saturates at the timeout so it can never wrap back into range.
   assign w_timeout = (r_cnt == TIMEOUT_CYCLES);
   assign w_cnt_inc = (r_cnt >= TIMEOUT_CYCLES) ? TIMEOUT_CYCLES : r_cnt + c_CNT_ONE;

   // Next-state and next-output decode; edges take priority over the timeout.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_hi_len_nxt = r_hi_len;
      w_period_nxt = r_period;
      w_tw_nxt     = r_tw;
      w_valid_nxt  = 1'b0;
      w_stuck_nxt  = r_stuck;
      w_level_nxt  = r_level;
      unique case (r_state)
         ST_IDLE: begin
            if (w_rise) begin
               w_state_nxt = ST_HIGH;
               w_cnt_nxt   = c_CNT_ONE;
            end
         end
         ST_HIGH: begin
            if (w_rise) begin
               w_cnt_nxt = c_CNT_ONE;
            end else if (w_fall) begin
               w_hi_len_nxt = r_cnt;
               w_cnt_nxt    = w_cnt_inc;
               w_state_nxt  = ST_LOW;
            end else if (w_timeout) begin
               w_stuck_nxt = 1'b1;
               w_level_nxt = w_level;
               w_state_nxt = ST_STUCK;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         ST_LOW: begin
            // LOW is only reachable through HIGH, so a full rise-fall-rise
            // has been observed whenever a rise arrives here.
            if (w_rise) begin
               w_period_nxt = r_cnt;
               w_tw_nxt     = r_hi_len;
               w_valid_nxt  = 1'b1;
               w_cnt_nxt    = c_CNT_ONE;
               w_state_nxt  = ST_HIGH;
            end else if (w_timeout) begin
               w_stuck_nxt = 1'b1;
               w_level_nxt = w_level;
               w_state_nxt = ST_STUCK;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         ST_STUCK: begin
            if (w_rise) begin
               w_stuck_nxt = 1'b0;
               w_cnt_nxt   = c_CNT_ONE;
               w_state_nxt = ST_HIGH;
            end else if (w_fall) begin
               // A high phase that started while stuck is incomplete: restart.
               w_stuck_nxt = 1'b0;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, counter and output registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_hi_len <= '0;
         r_period <= '0;
         r_tw     <= '0;
         r_valid  <= 1'b0;
         r_stuck  <= 1'b0;
         r_level  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_hi_len <= w_hi_len_nxt;
         r_period <= w_period_nxt;
         r_tw     <= w_tw_nxt;
         r_valid  <= w_valid_nxt;
         r_stuck  <= w_stuck_nxt;
         r_level  <= w_level_nxt;
      end
   end

   assign period_meas    = r_period;
   assign time_work_meas = r_tw;
   assign meas_valid     = r_valid;
   assign stuck          = r_stuck;
   assign stuck_level    = r_level;

endmodule
`default_nettype wire
